idma_ddr_rd_engine: RTL and testbench

- AXI4 read master that fetches instruction words from DDR.
- Sits directly upstream of the iDMA/iNoC interface: it drives that block's dma_rd_* port (req, addr, num, data, strb, valid/ready).
- Converts one {byte address, 32-bit word count} command into 4KB-safe AXI INCR bursts of 128-bit lines.
- Generates per-line byte strobes for partial first and last lines.

---
 rtl/idma_pkg.sv | 16 +
 rtl/idma_rd_strb_gen.sv | 21 ++
 rtl/idma_ddr_rd_engine.sv | 183 ++++++++++++++++++
 tb/tb_idma_ddr_rd_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_pkg.sv
// Shared types and AXI constants for the iDMA DDR read/write engines.
package idma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        AR,
        R,
        DONE
    } rd_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_16B   = 3'd4;
    localparam int         WORDS_PER_LINE = 4;

endpackage

// File: rtl/idma_rd_strb_gen.sv
// Byte-enable generator for one 128-bit line: masks words below the start
// offset on the first line and words past the final word on the last line.
module idma_rd_strb_gen
    import idma_pkg::*;
(
    input  logic        first,
    input  logic        last,
    input  logic [1:0]  off,
    input  logic [1:0]  last_word,
    output logic [15:0] strb
);

    always_comb begin
        strb = '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if ((!first || (2'(w) >= off)) && (!last || (2'(w) <= last_word)))
                strb[w*4 +: 4] = 4'hF;
        end
    end

endmodule

// File: rtl/idma_ddr_rd_engine.sv
// AXI4 read master: splits a {byte address, word count} command into 4KB-safe
// INCR bursts of 128-bit lines and streams them to the iDMA interface.
module idma_ddr_rd_engine
    import idma_pkg::*;
#(
    parameter int         DATA_WIDTH = 128,
    parameter int         STRB_WIDTH = DATA_WIDTH / 8,
    parameter int         ADDR_WIDTH = 32,
    parameter int         MAX_BURST  = 16,
    parameter logic [3:0] ID_VAL     = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_num,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic [3:0]            m_arid,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    output logic                  dma_rd_req,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [31:0]           dma_rd_num,
    output logic                  dma_rd_data_valid,
    input  logic                  dma_rd_data_ready,
    output logic [DATA_WIDTH-1:0] dma_rd_data,
    output logic [STRB_WIDTH-1:0] dma_rd_strb
);

    rd_state_e state, state_nxt;

    logic [ADDR_WIDTH-5:0] cur_line;
    logic [ADDR_WIDTH-1:0] lines_left;
    logic [8:0]            beats_left;
    logic [8:0]            blen;
    logic [8:0]            room;
    logic [1:0]            off_q;
    logic [1:0]            last_word_q;
    logic                  first_line;
    logic                  last_line;
    logic [15:0]           line_strb;
    logic [ADDR_WIDTH-1:0] end_word;
    logic [ADDR_WIDTH-1:0] total_lines;
    logic                  beat_acc;
    logic                  last_beat;
    logic                  unused_rlast;

    // The beat counter decides burst boundaries; RLAST is not trusted.
    assign unused_rlast = m_rlast;

    assign end_word    = ADDR_WIDTH'(cmd_addr[3:2]) + ADDR_WIDTH'(cmd_num) - ADDR_WIDTH'(1);
    assign total_lines = (end_word >> 2) + ADDR_WIDTH'(1);

    assign beat_acc  = (state == R) && m_rvalid && dma_rd_data_ready;
    assign last_beat = beat_acc && (beats_left == 9'd1);
    assign last_line = (lines_left == ADDR_WIDTH'(1));

    // Lines remaining before the next 4KB boundary (16 lines per 256 B, 256 per 4KB).
    assign room = 9'd256 - {1'b0, cur_line[7:0]};

    always_comb begin
        blen = 9'(MAX_BURST);
        if (lines_left < ADDR_WIDTH'(blen))
            blen = lines_left[8:0];
        if (room < blen)
            blen = room;
    end

    idma_rd_strb_gen u_strb_gen (
        .first     (first_line),
        .last      (last_line),
        .off       (off_q),
        .last_word (last_word_q),
        .strb      (line_strb)
    );

    assign m_arsize  = AXI_SIZE_16B;
    assign m_arburst = AXI_BURST_INCR;
    assign m_arid    = ID_VAL;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        busy              = 1'b0;
        done              = 1'b0;
        dma_rd_req        = 1'b0;
        m_arvalid         = 1'b0;
        m_araddr          = '0;
        m_arlen           = '0;
        m_rready          = 1'b0;
        dma_rd_data_valid = 1'b0;
        dma_rd_data       = '0;
        dma_rd_strb       = '0;
        case (state)
            IDLE: begin
                if (cmd_start)
                    state_nxt = (cmd_num == 32'd0) ? DONE : REQ;
            end
            REQ: begin
                busy       = 1'b1;
                dma_rd_req = 1'b1;
                state_nxt  = AR;
            end
            AR: begin
                busy      = 1'b1;
                m_arvalid = 1'b1;
                m_araddr  = {cur_line, 4'b0000};
                m_arlen   = 8'(blen - 9'd1);
                if (m_arready)
                    state_nxt = R;
            end
            R: begin
                busy              = 1'b1;
                m_rready          = dma_rd_data_ready;
                dma_rd_data_valid = m_rvalid;
                dma_rd_data       = m_rdata;
                dma_rd_strb       = line_strb;
                if (last_beat)
                    state_nxt = last_line ? DONE : AR;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_line    <= '0;
            lines_left  <= '0;
            beats_left  <= '0;
            off_q       <= '0;
            last_word_q <= '0;
            first_line  <= 1'b0;
            err         <= 1'b0;
            dma_rd_addr <= '0;
            dma_rd_num  <= '0;
        end else begin
            if (state == IDLE && cmd_start) begin
                err <= 1'b0;
                if (cmd_num != 32'd0) begin
                    dma_rd_addr <= cmd_addr;
                    dma_rd_num  <= cmd_num;
                    cur_line    <= cmd_addr[ADDR_WIDTH-1:4];
                    lines_left  <= total_lines;
                    off_q       <= cmd_addr[3:2];
                    last_word_q <= end_word[1:0];
                    first_line  <= 1'b1;
                end
            end
            if (state == AR && m_arready)
                beats_left <= blen;
            if (beat_acc) begin
                lines_left <= lines_left - ADDR_WIDTH'(1);
                cur_line   <= cur_line + 1'b1;
                beats_left <= beats_left - 9'd1;
                first_line <= 1'b0;
                if (m_rresp != 2'b00)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_idma_ddr_rd_engine.sv
// Directed bench for idma_ddr_rd_engine with a behavioural AXI read slave.
module tb_idma_ddr_rd_engine;

    logic         clk;
    logic         rst;
    logic         cmd_start;
    logic [31:0]  cmd_addr;
    logic [31:0]  cmd_num;
    logic         busy, done, err;
    logic         m_arvalid, m_arready;
    logic [31:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic [3:0]   m_arid;
    logic         m_rvalid, m_rready, m_rlast;
    logic [127:0] m_rdata;
    logic [1:0]   m_rresp;
    logic         dma_rd_req;
    logic [31:0]  dma_rd_addr, dma_rd_num;
    logic         dma_rd_data_valid, dma_rd_data_ready;
    logic [127:0] dma_rd_data;
    logic [15:0]  dma_rd_strb;

    idma_ddr_rd_engine dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_start         (cmd_start),
        .cmd_addr          (cmd_addr),
        .cmd_num           (cmd_num),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .m_arvalid         (m_arvalid),
        .m_arready         (m_arready),
        .m_araddr          (m_araddr),
        .m_arlen           (m_arlen),
        .m_arsize          (m_arsize),
        .m_arburst         (m_arburst),
        .m_arid            (m_arid),
        .m_rvalid          (m_rvalid),
        .m_rready          (m_rready),
        .m_rdata           (m_rdata),
        .m_rresp           (m_rresp),
        .m_rlast           (m_rlast),
        .dma_rd_req        (dma_rd_req),
        .dma_rd_addr       (dma_rd_addr),
        .dma_rd_num        (dma_rd_num),
        .dma_rd_data_valid (dma_rd_data_valid),
        .dma_rd_data_ready (dma_rd_data_ready),
        .dma_rd_data       (dma_rd_data),
        .dma_rd_strb       (dma_rd_strb)
    );

    int checks = 0;
    int passes = 0;

    logic [31:0]  ar_addr_q[$];
    logic [7:0]   ar_len_q[$];
    logic [127:0] beat_data_q[$];
    logic [15:0]  beat_strb_q[$];

    int beat_no  = 0;
    int err_beat = -1;
    logic err_at_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // AXI slave: drives at +1 after each edge, samples handshakes at +4.
    initial begin : slave
        int          rem;
        logic [31:0] raddr;
        logic        s_rst, s_hs_r, s_hs_ar;
        logic [31:0] s_ar_addr;
        logic [7:0]  s_ar_len;
        rem = 0; raddr = '0;
        s_rst = 1'b1; s_hs_r = 1'b0; s_hs_ar = 1'b0; s_ar_addr = '0; s_ar_len = '0;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (s_rst) begin
                rem = 0;
            end else begin
                if (s_hs_r) begin
                    rem = rem - 1;
                    raddr = raddr + 32'd16;
                    beat_no = beat_no + 1;
                end
                if (s_hs_ar) begin
                    raddr = s_ar_addr;
                    rem = int'(s_ar_len) + 1;
                    ar_addr_q.push_back(s_ar_addr);
                    ar_len_q.push_back(s_ar_len);
                end
            end
            m_rvalid = (rem != 0);
            m_rdata  = {4{raddr}};
            m_rlast  = (rem == 1);
            m_rresp  = ((rem != 0) && (beat_no == err_beat)) ? 2'd2 : 2'd0;
            #3;
            s_rst     = rst;
            s_hs_r    = m_rvalid && m_rready;
            s_hs_ar   = m_arvalid && m_arready;
            s_ar_addr = m_araddr;
            s_ar_len  = m_arlen;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issues one command and follows it to completion, checking handshake-level behaviour.
    task automatic run_xfer(input string tag, input logic [31:0] addr, input logic [31:0] num,
                            input bit toggle);
        int req_cnt = 0, hold_bad = 0, mirror_bad = 0;
        int done_it = -1, last_hs_it = -2;
        logic busy_at_done = 1'b1;
        ar_addr_q.delete(); ar_len_q.delete();
        beat_data_q.delete(); beat_strb_q.delete();
        beat_no = 0;
        dma_rd_data_ready = 1'b1;
        cmd_addr = addr; cmd_num = num; cmd_start = 1'b1;
        for (int it = 0; it < 400; it++) begin
            cyc();
            if (done) begin
                done_it = it;
                busy_at_done = busy;
                err_at_done = err;
                break;
            end
            if (dma_rd_req) req_cnt++;
            if (busy && (dma_rd_addr !== addr || dma_rd_num !== num)) hold_bad++;
            cmd_start = (it == 2);
            cmd_addr  = (it == 2) ? 32'hDEAD_0000 : addr;
            cmd_num   = (it == 2) ? 32'd99 : num;
            if (toggle) dma_rd_data_ready = ~dma_rd_data_ready;
            #1;
            if (m_rvalid && (m_rready !== dma_rd_data_ready)) mirror_bad++;
            if (dma_rd_data_valid && dma_rd_data_ready) begin
                beat_data_q.push_back(dma_rd_data);
                beat_strb_q.push_back(dma_rd_strb);
                last_hs_it = it;
            end
        end
        cmd_start = 1'b0;
        dma_rd_data_ready = 1'b1;
        check({tag, " done seen"}, done_it >= 0, 1'b1);
        check({tag, " req pulses"}, req_cnt, 1);
        check({tag, " addr/num held"}, hold_bad, 0);
        check({tag, " rready mirror"}, mirror_bad, 0);
        check({tag, " done after last beat"}, done_it, last_hs_it + 1);
        check({tag, " busy low at done"}, busy_at_done, 1'b0);
        cyc();
        check({tag, " done one cycle"}, done, 1'b0);
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] base,
                               input logic [15:0] s_first, input logic [15:0] s_last);
        int bad = 0;
        logic [15:0] es;
        logic [31:0] la;
        check({tag, " beat count"}, beat_data_q.size(), n);
        check({tag, " first strb"}, beat_strb_q[0], s_first);
        check({tag, " last strb"}, beat_strb_q[n-1], s_last);
        for (int k = 0; k < n && k < beat_data_q.size(); k++) begin
            es = (k == 0) ? s_first : (k == n - 1) ? s_last : 16'hFFFF;
            la = base + 32'(k * 16);
            if (beat_data_q[k] !== {4{la}} || beat_strb_q[k] !== es) bad++;
        end
        check({tag, " beat data/strb"}, bad, 0);
    endtask

    initial begin : main
        rst = 1'b1; cmd_start = 1'b0; cmd_addr = '0; cmd_num = '0; dma_rd_data_ready = 1'b1;
        err_at_done = 1'b0;
        repeat (3) cyc();
        check("reset busy/done/err", {busy, done, err}, 3'b000);
        check("reset ar/r ctl", {m_arvalid, m_rready, dma_rd_data_valid, dma_rd_req}, 4'b0000);
        check("reset araddr/arlen", {m_araddr, m_arlen}, 40'h0);
        check("reset dma addr/num", {dma_rd_addr, dma_rd_num}, 64'h0);
        check("reset data/strb", {dma_rd_data, dma_rd_strb}, 144'h0);
        check("arsize", m_arsize, 3'd4);
        check("arburst", m_arburst, 2'b01);
        check("arid", m_arid, 4'h0);
        rst = 1'b0;
        cyc();

        run_xfer("t1", 32'h0000_1000, 32'd8, 1'b0);
        check("t1 ar count", ar_addr_q.size(), 1);
        check("t1 araddr", ar_addr_q[0], 32'h0000_1000);
        check("t1 arlen", ar_len_q[0], 8'd1);
        check_beats("t1", 2, 32'h0000_1000, 16'hFFFF, 16'hFFFF);

        run_xfer("t2", 32'h0000_1004, 32'd6, 1'b0);
        check("t2 ar count", ar_addr_q.size(), 1);
        check("t2 araddr", ar_addr_q[0], 32'h0000_1000);
        check("t2 arlen", ar_len_q[0], 8'd1);
        check_beats("t2", 2, 32'h0000_1000, 16'hFFF0, 16'h0FFF);

        run_xfer("t3", 32'h0000_2008, 32'd1, 1'b0);
        check("t3 araddr", ar_addr_q[0], 32'h0000_2000);
        check("t3 arlen", ar_len_q[0], 8'd0);
        check_beats("t3", 1, 32'h0000_2000, 16'h0F00, 16'h0F00);

        run_xfer("t4", 32'h0000_0FE0, 32'd64, 1'b0);
        check("t4 ar count", ar_addr_q.size(), 2);
        check("t4 ar0", {ar_addr_q[0], ar_len_q[0]}, {32'h0000_0FE0, 8'd1});
        check("t4 ar1", {ar_addr_q[1], ar_len_q[1]}, {32'h0000_1000, 8'd13});
        check_beats("t4", 16, 32'h0000_0FE0, 16'hFFFF, 16'hFFFF);

        run_xfer("t5", 32'h0000_0000, 32'd80, 1'b1);
        check("t5 ar count", ar_addr_q.size(), 2);
        check("t5 ar0", {ar_addr_q[0], ar_len_q[0]}, {32'h0000_0000, 8'd15});
        check("t5 ar1", {ar_addr_q[1], ar_len_q[1]}, {32'h0000_0100, 8'd3});
        check_beats("t5", 20, 32'h0000_0000, 16'hFFFF, 16'hFFFF);

        err_beat = 2;
        run_xfer("t6", 32'h0000_3000, 32'd12, 1'b0);
        err_beat = -1;
        check("t6 err at done", err_at_done, 1'b1);
        check("t6 err sticky", err, 1'b1);
        check_beats("t6", 3, 32'h0000_3000, 16'hFFFF, 16'hFFFF);
        cmd_addr = 32'h0000_4000; cmd_num = 32'd4; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        check("t7 err cleared by start", err, 1'b0);
        repeat (10) cyc();
        check("t7 idle after clean xfer", {busy, err}, 2'b00);

        ar_addr_q.delete();
        cmd_addr = 32'h0000_5000; cmd_num = 32'd0; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        check("t8 num0 done", done, 1'b1);
        check("t8 num0 busy/req/arvalid", {busy, dma_rd_req, m_arvalid}, 3'b000);
        cyc();
        check("t8 num0 done pulse", done, 1'b0);
        check("t8 num0 no ar", ar_addr_q.size(), 0);
        check("t8 num0 addr not latched", dma_rd_addr, 32'h0000_4000);

        cmd_addr = 32'h0000_0000; cmd_num = 32'd80; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dma_rd_data_valid) break;
            cyc();
        end
        check("t9 reached R", dma_rd_data_valid, 1'b1);
        rst = 1'b1;
        cyc();
        check("t9 rst busy/done/err", {busy, done, err}, 3'b000);
        check("t9 rst ctl", {m_arvalid, m_rready, dma_rd_data_valid, dma_rd_req}, 4'b0000);
        check("t9 rst dma addr/num", {dma_rd_addr, dma_rd_num}, 64'h0);
        check("t9 rst data/strb", {dma_rd_data, dma_rd_strb}, 144'h0);
        rst = 1'b0;
        repeat (2) cyc();

        run_xfer("t10", 32'h0000_2008, 32'd1, 1'b0);
        check_beats("t10", 1, 32'h0000_2000, 16'h0F00, 16'h0F00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
